// File: rtl/reg_writeback_queue_pkg.sv
// rtl/reg_writeback_queue_pkg.sv - shared constants and types for the register writeback queue
package reg_writeback_queue_pkg;

  localparam int DATA_INDEX_LIMIT     = 31;
  localparam int REG_ADDR_INDEX_LIMIT = 4;
  localparam int WBQ_DEPTH            = 4;
  localparam int WBQ_AW               = REG_ADDR_INDEX_LIMIT + 1;
  localparam int WBQ_DW               = DATA_INDEX_LIMIT + 1;

  // Which side owns the single-ported RF this cycle.
  typedef enum logic [1:0] {
    RF_IDLE = 2'd0,
    RF_RD   = 2'd1,
    RF_WR   = 2'd2
  } rf_op_e;

  function automatic int wbq_count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_writeback_queue_if.sv
// rtl/reg_writeback_queue_if.sv - writeback request handshake between execute/memory and the queue
interface reg_writeback_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;

  modport master (
    output in_valid,
    output in_addr,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/wbq_fwd_match.sv
// rtl/wbq_fwd_match.sv - DEPTH-way address compare with youngest-match select (WBQ_FORWARD_EN only)
`ifdef WBQ_FORWARD_EN
module wbq_fwd_match #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic [AW-1:0] addr_q [DEPTH],
  input  logic [DW-1:0] data_q [DEPTH],
  input  logic [PW-1:0] head,
  input  logic [CW-1:0] count,
  input  logic [AW-1:0] fwd_addr,
  output logic          hit,
  output logic [DW-1:0] data
);

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    logic [PW-1:0] idx;
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((CW'(k) < count) && (fwd_addr != '0) && (addr_q[idx] == fwd_addr)) begin
        hit  = 1'b1;
        data = data_q[idx];
      end
    end
  end

endmodule
`endif

// File: rtl/reg_writeback_queue.sv
// rtl/reg_writeback_queue.sv - writeback FIFO feeding the 32x32 RF write port with read/write arbitration
// Optional operand forwarding from queued entries is enabled by defining WBQ_FORWARD_EN.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = WBQ_DEPTH,
  parameter int AW    = WBQ_AW,
  parameter int DW    = WBQ_DW,
  parameter int CW    = wbq_count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_writeback_queue_if.slave  wb,
  input  logic                  rd_req,
  output logic                  rd_gnt,
  output logic                  rf_read,
  output logic                  rf_write,
  output logic [AW-1:0]         rf_addr_w,
  output logic [DW-1:0]         rf_data_w,
  output logic [CW-1:0]         count,
  output logic                  empty,
  output logic                  full,
  input  logic [AW-1:0]         fwd_addr1,
  input  logic [AW-1:0]         fwd_addr2,
  output logic                  fwd_hit1,
  output logic                  fwd_hit2,
  output logic [DW-1:0]         fwd_data1,
  output logic [DW-1:0]         fwd_data2
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  rf_op_e        rf_op;
  logic          push;
  logic          store;
  logic          pop;

  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CW'(DEPTH));
  // Registered FULL only: a pop in the same cycle does not open a slot.
  assign wb.in_ready = !full;

  assign push  = wb.in_valid && wb.in_ready;
  assign store = push && (wb.in_addr != '0);
  assign pop   = rf_write;

  // Reads win unless the queue is full, so writes cannot starve forever.
  always_comb begin
    rf_op = RF_IDLE;
    if (!rst) begin
      if (!empty && (!rd_req || full)) begin
        rf_op = RF_WR;
      end else if (rd_req) begin
        rf_op = RF_RD;
      end
    end
  end

  assign rf_write  = (rf_op == RF_WR);
  assign rf_read   = (rf_op == RF_RD);
  assign rd_gnt    = rf_read;
  assign rf_addr_w = addr_q[rd_ptr];
  assign rf_data_w = data_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (store) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_q + CW'(store) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      addr_q[wr_ptr] <= wb.in_addr;
      data_q[wr_ptr] <= wb.in_data;
    end
  end

`ifdef WBQ_FORWARD_EN
  logic          hit1_raw;
  logic          hit2_raw;
  logic [DW-1:0] data1_raw;
  logic [DW-1:0] data2_raw;

  wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW), .CW(CW)) u_fwd1 (
    .addr_q   (addr_q),
    .data_q   (data_q),
    .head     (rd_ptr),
    .count    (count_q),
    .fwd_addr (fwd_addr1),
    .hit      (hit1_raw),
    .data     (data1_raw)
  );

  wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW), .CW(CW)) u_fwd2 (
    .addr_q   (addr_q),
    .data_q   (data_q),
    .head     (rd_ptr),
    .count    (count_q),
    .fwd_addr (fwd_addr2),
    .hit      (hit2_raw),
    .data     (data2_raw)
  );

  assign fwd_hit1  = hit1_raw && !rst;
  assign fwd_hit2  = hit2_raw && !rst;
  assign fwd_data1 = data1_raw;
  assign fwd_data2 = data2_raw;
`else
  wire unused_fwd = ^{fwd_addr1, fwd_addr2};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

  a_rd_wr_excl : assert property (@(posedge clk) !(rf_read && rf_write));
  a_count_max  : assert property (@(posedge clk) disable iff (rst) count_q <= CW'(DEPTH));

endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb/tb_reg_writeback_queue.sv - scoreboard bench for reg_writeback_queue
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req;
  logic        rd_gnt, rf_read, rf_write;
  logic [4:0]  rf_addr_w;
  logic [31:0] rf_data_w;
  logic [2:0]  count;
  logic        empty, full;
  logic [4:0]  fwd_addr1, fwd_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;

  int total = 0;
  int bad   = 0;
  logic [36:0] exp_q [$];

  reg_writeback_queue_if #(.AW(5), .DW(32)) wb ();

  reg_writeback_queue dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .rd_req    (rd_req),
    .rd_gnt    (rd_gnt),
    .rf_read   (rf_read),
    .rf_write  (rf_write),
    .rf_addr_w (rf_addr_w),
    .rf_data_w (rf_data_w),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .fwd_addr1 (fwd_addr1),
    .fwd_addr2 (fwd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    int n = 0;
    wb.in_valid = 1'b1;
    wb.in_addr  = a;
    wb.in_data  = d;
    while (!wb.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("push_ready_timeout", {63'd0, wb.in_ready}, 64'd1);
    @(posedge clk);
    if (a != 5'd0) exp_q.push_back({a, d});
    #1;
    wb.in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!empty && n < 30) begin
      tick();
      n++;
    end
    chk("drain_timeout", {63'd0, empty}, 64'd1);
  endtask

  // Monitor: every RF write must match the oldest expected entry.
  always @(negedge clk) begin
    logic [36:0] e;
    chk("rd_wr_excl", {63'd0, rf_read & rf_write}, 64'd0);
    if (rst) begin
      chk("rst_outputs", {59'd0, rf_write, rf_read, rd_gnt, fwd_hit1, fwd_hit2}, 64'd0);
    end else if (rf_write) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {63'd0, rf_write}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rf_write_entry", {27'd0, rf_addr_w, rf_data_w}, {27'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rd_req = 1'b0;
    fwd_addr1 = 5'd0;
    fwd_addr2 = 5'd0;
    wb.in_valid = 1'b1;
    wb.in_addr = 5'd3;
    wb.in_data = 32'h5555_AAAA;

    // 1 reset with in_valid asserted
    tick();
    tick();
    chk("rst_count", {61'd0, count}, 64'd0);
    chk("rst_empty", {63'd0, empty}, 64'd1);
    chk("rst_rf_write", {63'd0, rf_write}, 64'd0);
    chk("rst_in_ready", {63'd0, wb.in_ready}, 64'd1);
    wb.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_count", {61'd0, count}, 64'd0);
    chk("post_rst_in_ready", {63'd0, wb.in_ready}, 64'd1);

    // 2 single push drains next cycle
    push(5'd5, 32'hDEADBEEF);
    chk("t2_rf_write", {63'd0, rf_write}, 64'd1);
    chk("t2_addr", {59'd0, rf_addr_w}, 64'd5);
    chk("t2_data", {32'd0, rf_data_w}, 64'hDEADBEEF);
    tick();
    chk("t2_empty", {63'd0, empty}, 64'd1);

    // 3 fill with reads pending, then wrap on 5th push
    rd_req = 1'b1;
    #1;
    chk("t3_gnt_empty", {63'd0, rd_gnt}, 64'd1);
    push(5'd1, 32'h101);
    push(5'd2, 32'h102);
    chk("t3_count2", {61'd0, count}, 64'd2);
    chk("t3_gnt_partial", {63'd0, rd_gnt}, 64'd1);
    push(5'd3, 32'h103);
    push(5'd4, 32'h104);
    chk("t3_full", {63'd0, full}, 64'd1);
    chk("t3_full_write", {63'd0, rf_write}, 64'd1);
    chk("t3_full_gnt", {63'd0, rd_gnt}, 64'd0);
    chk("t3_full_ready", {63'd0, wb.in_ready}, 64'd0);
    chk("t3_head", {59'd0, rf_addr_w}, 64'd1);
    push(5'd6, 32'h106);
    chk("t3_wrap_count", {61'd0, count}, 64'd4);
    rd_req = 1'b0;
    wait_empty();

    // simultaneous push and pop keeps count
    push(5'd10, 32'hAA);
    chk("sim_count1", {61'd0, count}, 64'd1);
    push(5'd11, 32'hBB);
    chk("sim_count_same", {61'd0, count}, 64'd1);
    chk("sim_head", {59'd0, rf_addr_w}, 64'd11);
    wait_empty();

    // 4 R0 writeback discarded
    push(5'd0, 32'h1234);
    chk("t4_count", {61'd0, count}, 64'd0);
    chk("t4_no_write", {63'd0, rf_write}, 64'd0);

    // 5 forwarding, youngest match
    rd_req = 1'b1;
    push(5'd7, 32'hA);
    push(5'd7, 32'hB);
    fwd_addr1 = 5'd7;
    fwd_addr2 = 5'd0;
    #1;
`ifdef WBQ_FORWARD_EN
    chk("t5_hit1", {63'd0, fwd_hit1}, 64'd1);
    chk("t5_data1", {32'd0, fwd_data1}, 64'hB);
`else
    chk("t5_hit1", {63'd0, fwd_hit1}, 64'd0);
    chk("t5_data1", {32'd0, fwd_data1}, 64'd0);
`endif
    chk("t5_hit2_r0", {63'd0, fwd_hit2}, 64'd0);
    fwd_addr2 = 5'd8;
    #1;
    chk("t5_hit2_miss", {63'd0, fwd_hit2}, 64'd0);
    fwd_addr1 = 5'd0;
    fwd_addr2 = 5'd0;
    rd_req = 1'b0;
    wait_empty();

    // 6 reset with 3 entries queued
    rd_req = 1'b1;
    push(5'd20, 32'h20);
    push(5'd21, 32'h21);
    push(5'd22, 32'h22);
    chk("t6_count3", {61'd0, count}, 64'd3);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_rst_no_write", {63'd0, rf_write}, 64'd0);
    tick();
    chk("t6_count0", {61'd0, count}, 64'd0);
    chk("t6_empty", {63'd0, empty}, 64'd1);
    rst = 1'b0;
    rd_req = 1'b0;
    tick();
    chk("t6_after_write", {63'd0, rf_write}, 64'd0);
    tick();
    chk("scoreboard_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
